sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port between two sram-like masters: m0 = instruction fetch, m1 = data access.
- The slave port feeds the CPU-to-AXI bridge.
- An owner-tag FIFO records which master issued each accepted address, so in-order data_ok responses go back to the correct master.
- Sits between the CPU core/caches and the AXI interface bridge.

Parameters:
- DEPTH, 4, maximum outstanding accepted-but-unanswered transactions (owner FIFO entries, >=1).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- m0_req  in  1  inst master request
- m0_wr  in  1  inst master write
- m0_size  in  2  0=byte, 1=half, 2=word
- m0_addr  in  ADDR_W  inst master address
- m0_wdata  in  DATA_W  inst master write data
- m0_rdata  out  DATA_W  read data to m0
- m0_addr_ok  out  1  m0 address accepted
- m0_data_ok  out  1  m0 response
- m1_req, m1_wr, m1_size, m1_addr, m1_wdata, m1_rdata, m1_addr_ok, m1_data_ok: same as m0, for the data master
- s_req  out  1  slave request
- s_wr  out  1  slave write
- s_size  out  2  slave size
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data
- s_addr_ok  in  1  slave address accepted
- s_data_ok  in  1  slave response

Behaviour:
- Clock clk; reset resetn, synchronous, active-low.
- Reset state:
  - Owner FIFO empty: count=0, rd_ptr=wr_ptr=0.
  - Round-robin pointer (if enabled) = m0.
- Grant (combinational, recomputed every cycle; no lock, because nothing is committed before addr_ok):
  - Only one requester: it wins.
  - Both request: m1 wins (fixed priority, default).
- Slave request path:
  - s_req = granted req && (count != DEPTH).
  - s_wr/s_size/s_addr/s_wdata are muxed from the granted master; m0 fields when there is no grant.
- Address handshake:
  - mX_addr_ok = s_addr_ok && s_req && grant==X, in the same cycle (zero added latency).
  - Non-granted master sees addr_ok=0 and must hold req and fields stable.
  - On the accept edge, push the owner tag (0/1) at wr_ptr.
  - wr_ptr wraps DEPTH-1 -> 0 explicitly; DEPTH need not be a power of two.
- Response path:
  - mX_data_ok = s_data_ok && count!=0 && head_tag==X.
  - m0_rdata = m1_rdata = s_rdata (broadcast; only the tagged master's data_ok is meaningful).
  - On s_data_ok with count!=0, pop: rd_ptr advances with wrap.
- Full: count==DEPTH forces s_req=0 and both addr_ok=0.
  - A pop in the same cycle does not unblock the push; accept resumes the next cycle.
- Empty: s_data_ok with count==0 is spurious; it is ignored, no master data_ok, count stays 0.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When count==0, the pushed tag does not serve the same-cycle s_data_ok.
- Count width is $clog2(DEPTH+1); it never exceeds DEPTH or underflows.
- Reset mid-operation: FIFO is cleared; responses for pre-reset transactions are dropped. The downstream bridge is reset by the same resetn.
- Outputs are combinational; with all inputs 0 every output is 0.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A 1-bit last_grant register (reset 0 = m0) is updated on every accepted address.
  - On contention the master that is not last_grant wins.
- Undefined:
  - Fixed priority m1 > m0; no last_grant register.

Decomposition:
- Package sram_arb_pkg holds:
  - MID_INST=1'b0, MID_DATA=1'b1.
  - Size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
- One sub-module, sram_arb_tag_fifo:
  - Parameterised DEPTH, 1-bit tag.
  - push/pop/tag_in/head/count/full/empty.
  - Wrap pointers and occupancy counter.

Test Plan:
- m0 read 0x1000 alone, slave accepts immediately, s_data_ok 3 cycles later with s_rdata=0xDEADBEEF -> m0_addr_ok same cycle; m0_data_ok=1 with m0_rdata=0xDEADBEEF; m1_data_ok=0.
- m0 and m1 both request in one cycle (m1 write 0x2000 data 0x55, size 2) -> fixed: s_addr=0x2000, s_wr=1, m1_addr_ok=1, m0 next; RR_EN with last_grant=m1: m0 served first.
- Issue 4 interleaved requests (m0,m1,m1,m0) with DEPTH=4 and no responses, then a 5th -> 5th sees s_req=0 and addr_ok=0; 4 responses route to tags m0,m1,m1,m0 in order.
- Full FIFO, s_data_ok and new m1_req in the same cycle -> no accept that cycle; accept the next cycle; count 4->3->4.
- s_data_ok with empty FIFO -> no master data_ok; count stays 0.
- Reset asserted with count=2 -> next cycle count=0; a following s_data_ok produces no master data_ok.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants for the sram-like arbiter: master ids and transfer size encodings.
package sram_arb_pkg;

  localparam logic MID_INST = 1'b0;
  localparam logic MID_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Owner-tag FIFO: one bit per accepted address, popped in order as responses return.
module sram_arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         tag_in,
  output logic                         head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem    <= {DEPTH{MID_INST}};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= tag_in;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave sram-like arbiter (m0 = inst, m1 = data) with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority m1 > m0.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          gnt;
  logic          accept;
  logic          pop;
  logic          head;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= MID_INST;
    end else if (accept) begin
      last_grant <= gnt;
    end
  end

  always_comb begin
    if (m0_req && m1_req) begin
      gnt = ~last_grant;
    end else begin
      gnt = m1_req ? MID_DATA : MID_INST;
    end
  end
`else
  assign gnt = m1_req ? MID_DATA : MID_INST;
`endif

  // Grant is free to move each cycle: nothing is committed until addr_ok.
  always_comb begin
    s_req   = (m0_req || m1_req) && !full;
    s_wr    = m0_wr;
    s_size  = m0_size;
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    if (gnt == MID_DATA) begin
      s_wr    = m1_wr;
      s_size  = m1_size;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  assign accept     = s_req && s_addr_ok;
  assign m0_addr_ok = accept && (gnt == MID_INST);
  assign m1_addr_ok = accept && (gnt == MID_DATA);

  // Responses with nothing outstanding are dropped.
  assign pop        = s_data_ok && !empty;
  assign m0_data_ok = pop && (head == MID_INST);
  assign m1_data_ok = pop && (head == MID_DATA);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  sram_arb_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .tag_in (gnt),
    .head   (head),
    .count  (fifo_count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (fifo_count <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: grant, full/empty boundaries, tag routing and reset.
module tb_sram_like_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]        m0_size, m1_size, s_size;
  logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic              m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic              s_req, s_wr, s_addr_ok, s_data_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_req     (m0_req),
    .m0_wr      (m0_wr),
    .m0_size    (m0_size),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_rdata   (m0_rdata),
    .m0_addr_ok (m0_addr_ok),
    .m0_data_ok (m0_data_ok),
    .m1_req     (m1_req),
    .m1_wr      (m1_wr),
    .m1_size    (m1_size),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_rdata   (m1_rdata),
    .m1_addr_ok (m1_addr_ok),
    .m1_data_ok (m1_data_ok),
    .s_req      (s_req),
    .s_wr       (s_wr),
    .s_size     (s_size),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
    .s_addr_ok  (s_addr_ok),
    .s_data_ok  (s_data_ok)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    m0_req = 1'b0; m0_wr = 1'b0; m0_size = SZ_BYTE; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_size = SZ_BYTE; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
  endtask

  // One master requests alone, the slave accepts; that master must see addr_ok.
  task automatic push_one(input logic m, input string tag);
    idle();
    if (m == MID_DATA) begin
      m1_req = 1'b1; m1_addr = 32'h3000; m1_size = SZ_WORD;
    end else begin
      m0_req = 1'b1; m0_addr = 32'h4000; m0_size = SZ_WORD;
    end
    s_addr_ok = 1'b1;
    #2;
    check_eq({tag, "_m0_addr_ok"}, m0_addr_ok, (m == MID_INST));
    check_eq({tag, "_m1_addr_ok"}, m1_addr_ok, (m == MID_DATA));
    tick();
    idle();
  endtask

  // A response arrives; only the master at the head of the tag FIFO gets data_ok.
  task automatic expect_resp(input logic m, input string tag);
    idle();
    s_data_ok = 1'b1;
    s_rdata   = 32'hA5A50000 | 32'(checks);
    #2;
    check_eq({tag, "_m0_data_ok"}, m0_data_ok, (m == MID_INST));
    check_eq({tag, "_m1_data_ok"}, m1_data_ok, (m == MID_DATA));
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    #2;
    check_eq("rst_s_req", s_req, 1'b0);
    check_eq("rst_m0_addr_ok", m0_addr_ok, 1'b0);
    check_eq("rst_m1_addr_ok", m1_addr_ok, 1'b0);
    check_eq("rst_m0_data_ok", m0_data_ok, 1'b0);
    check_eq("rst_m1_data_ok", m1_data_ok, 1'b0);
    check_eq("rst_s_addr", s_addr, 32'h0);
    tick();

    // m0 read alone, response three cycles later.
    m0_req = 1'b1; m0_addr = 32'h1000; m0_size = SZ_WORD; s_addr_ok = 1'b1;
    #2;
    check_eq("t1_s_req", s_req, 1'b1);
    check_eq("t1_s_addr", s_addr, 32'h1000);
    check_eq("t1_m0_addr_ok", m0_addr_ok, 1'b1);
    check_eq("t1_m1_addr_ok", m1_addr_ok, 1'b0);
    tick();
    idle();
    repeat (2) tick();
    s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF;
    #2;
    check_eq("t1_m0_data_ok", m0_data_ok, 1'b1);
    check_eq("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check_eq("t1_m1_data_ok", m1_data_ok, 1'b0);
    tick();
    idle();

    // Contention: m1 wins (also under round-robin, since m0 was granted last).
    m0_req = 1'b1; m0_addr = 32'h1000; m0_size = SZ_WORD;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h55; m1_size = SZ_WORD;
    s_addr_ok = 1'b1;
    #2;
    check_eq("t2_s_addr", s_addr, 32'h2000);
    check_eq("t2_s_wr", s_wr, 1'b1);
    check_eq("t2_s_wdata", s_wdata, 32'h55);
    check_eq("t2_s_size", s_size, SZ_WORD);
    check_eq("t2_m1_addr_ok", m1_addr_ok, 1'b1);
    check_eq("t2_m0_addr_ok", m0_addr_ok, 1'b0);
    tick();
    m1_req = 1'b0;
    #2;
    check_eq("t2_m0_next_addr_ok", m0_addr_ok, 1'b1);
    check_eq("t2_m0_next_s_addr", s_addr, 32'h1000);
    tick();
    idle();
    expect_resp(MID_DATA, "t2_r0");
    expect_resp(MID_INST, "t2_r1");

    // Fill to DEPTH, then a fifth request is blocked.
    push_one(MID_INST, "t3_p0");
    push_one(MID_DATA, "t3_p1");
    push_one(MID_DATA, "t3_p2");
    push_one(MID_INST, "t3_p3");
    m1_req = 1'b1; m1_addr = 32'h5000; s_addr_ok = 1'b1;
    #2;
    check_eq("t3_full_s_req", s_req, 1'b0);
    check_eq("t3_full_m1_addr_ok", m1_addr_ok, 1'b0);
    check_eq("t3_full_m0_addr_ok", m0_addr_ok, 1'b0);
    tick();

    // Full with a same-cycle response: no accept until the next cycle.
    s_data_ok = 1'b1;
    #2;
    check_eq("t4_pop_m0_data_ok", m0_data_ok, 1'b1);
    check_eq("t4_pop_s_req", s_req, 1'b0);
    check_eq("t4_pop_m1_addr_ok", m1_addr_ok, 1'b0);
    tick();
    s_data_ok = 1'b0;
    #2;
    check_eq("t4_resume_m1_addr_ok", m1_addr_ok, 1'b1);
    tick();
    m1_req = 1'b0; m0_req = 1'b1;
    #2;
    check_eq("t4_refull_s_req", s_req, 1'b0);
    tick();
    idle();
    expect_resp(MID_DATA, "t4_r0");
    expect_resp(MID_DATA, "t4_r1");
    expect_resp(MID_INST, "t4_r2");
    expect_resp(MID_DATA, "t4_r3");

    // Spurious response while empty.
    s_data_ok = 1'b1;
    #2;
    check_eq("t5_spur_m0_data_ok", m0_data_ok, 1'b0);
    check_eq("t5_spur_m1_data_ok", m1_data_ok, 1'b0);
    tick();
    // Push and response together at empty: the new tag is not served this cycle.
    m0_req = 1'b1; m0_addr = 32'h6000; s_addr_ok = 1'b1;
    #2;
    check_eq("t5_pp_m0_addr_ok", m0_addr_ok, 1'b1);
    check_eq("t5_pp_m0_data_ok", m0_data_ok, 1'b0);
    tick();
    idle();
    expect_resp(MID_INST, "t5_pp_resp");

    // Count must be back at 0: exactly DEPTH more accepts fit.
    push_one(MID_INST, "t5_f0");
    push_one(MID_DATA, "t5_f1");
    push_one(MID_INST, "t5_f2");
    push_one(MID_DATA, "t5_f3");
    m0_req = 1'b1; s_addr_ok = 1'b1;
    #2;
    check_eq("t5_full_s_req", s_req, 1'b0);
    tick();
    idle();
    expect_resp(MID_INST, "t6_r0");
    expect_resp(MID_DATA, "t6_r1");

    // Reset with two outstanding; their responses are dropped.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    s_data_ok = 1'b1;
    #2;
    check_eq("t6_post_rst_m0_data_ok", m0_data_ok, 1'b0);
    check_eq("t6_post_rst_m1_data_ok", m1_data_ok, 1'b0);
    tick();
    idle();
    push_one(MID_DATA, "t6_f0");
    push_one(MID_DATA, "t6_f1");
    push_one(MID_INST, "t6_f2");
    push_one(MID_DATA, "t6_f3");
    m1_req = 1'b1; s_addr_ok = 1'b1;
    #2;
    check_eq("t6_full_s_req", s_req, 1'b0);
    tick();
    idle();
    expect_resp(MID_DATA, "t6_d0");

    #2;
    check_eq("end_idle_s_req", s_req, 1'b0);
    check_eq("end_idle_s_addr", s_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
